// File: rtl/rr_mux8_arbiter.sv
// rr_mux8_arbiter: round-robin burst arbiter driving mux8x1 selects and a one-hot grant.
module rr_mux8_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CW        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic [7:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       out_valid,
    output logic [2:0] idx
);
    typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST == 0 ? 0 : MAX_BURST - 1);
    state_t        state_q, state_d;
    logic [2:0]    last_q, last_d, idx_q, idx_d, win;
    logic [7:0]    gnt_q, gnt_d;
    logic          vld_q, vld_d, found, beat, cap;
    logic [CW-1:0] bcnt_q, bcnt_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 3'd7;
            idx_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            bcnt_q  <= bcnt_d;
        end
    end
    // first requester after the previous owner, wrapping mod 8
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!found && req[last_q + 3'(k)]) begin
                found = 1'b1;
                win   = last_q + 3'(k);
            end
        end
    end
    assign beat = vld_q & out_ready;
    assign cap  = (MAX_BURST != 0) && (bcnt_q == LAST_BEAT);
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    gnt_d   = 8'd1 << win;
                    idx_d   = win;
                    vld_d   = 1'b1;
                    bcnt_d  = '0;
                end else begin
                    idx_d  = '0;
                    bcnt_d = '0;
                end
            end
            BUSY: begin
                if (!req[idx_q] || (beat && cap && |(req & ~gnt_q))) begin
                    state_d = TURN;
                    last_d  = idx_q;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                end else if (beat) begin
                    bcnt_d = cap ? '0 : bcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        gnt          = gnt_q;
        idx          = idx_q;
        {s0, s1, s2} = idx_q;
        out_valid    = vld_q;
    end
endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// tb_rr_mux8_arbiter: directed checks of grant order, burst rotation, handoff gaps and reset.
module tb_rr_mux8_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       out_ready = 1'b1;
    logic [7:0] gnt;
    logic       s0, s1, s2, out_valid;
    logic [2:0] idx;
    int         total = 0;
    int         bad = 0;

    rr_mux8_arbiter #(.MAX_BURST(4), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .gnt(gnt), .s0(s0), .s1(s1), .s2(s2), .out_valid(out_valid), .idx(idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // packs {out_valid, s0 s1 s2, idx, gnt}
    task automatic expect_st(input string tag, input logic v, input logic [2:0] i, input logic [7:0] g);
        check(tag, {17'd0, out_valid, s0, s1, s2, idx, gnt}, {17'd0, v, i, i, g});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        #1;
        expect_st("reset", 0, 0, 8'h00);
        for (int c = 0; c < 5; c++) step();
        expect_st("idle_no_req", 0, 0, 8'h00);

        // single requester b, then drop
        out_ready = 1'b0;
        req = 8'h02;
        step();
        expect_st("grant_b", 1, 1, 8'h02);
        step();
        step();
        expect_st("hold_b", 1, 1, 8'h02);
        req = 8'h00;
        step();
        expect_st("turn_b", 0, 1, 8'h00);
        step();
        expect_st("idle_after_b", 0, 1, 8'h00);
        step();
        expect_st("idle_idx_clear", 0, 0, 8'h00);

        // all requesting: 4-beat bursts rotate 0..7,0 with a TURN and an IDLE cycle between
        do_reset();
        out_ready = 1'b1;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            for (int b = 0; b < 4; b++) begin
                step();
                expect_st($sformatf("rr_gnt%0d_%0d", k, b), 1, 3'(k % 8), 8'd1 << (k % 8));
            end
            step();
            expect_st($sformatf("rr_turn%0d", k), 0, 3'(k % 8), 8'h00);
            step();
            check($sformatf("rr_gap%0d", k), {31'd0, out_valid}, 32'd0);
        end
        req = 8'h00;
        step();
        step();

        // stalled owner keeps grant, then rotates to 7 after 4 beats
        do_reset();
        out_ready = 1'b0;
        req = 8'h81;
        step();
        expect_st("stall_grant0", 1, 0, 8'h01);
        for (int c = 0; c < 10; c++) step();
        expect_st("stall_hold0", 1, 0, 8'h01);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            expect_st($sformatf("stall_beat%0d", c), 1, 0, 8'h01);
        end
        step();
        expect_st("stall_turn", 0, 0, 8'h00);
        step();
        step();
        expect_st("rotate_to7", 1, 7, 8'h80);
        req = 8'h00;
        step();
        step();

        // lone requester 4: bcnt wraps, no TURN gaps
        req = 8'h10;
        for (int c = 0; c < 12; c++) begin
            step();
            expect_st($sformatf("lone4_%0d", c), 1, 4, 8'h10);
        end
        req = 8'h00;
        step();
        expect_st("lone4_turn", 0, 4, 8'h00);
        step();

        // owner 5 drops on its 4th beat; next search starts at 6 (not 2)
        req = 8'h64;
        step();
        expect_st("own5", 1, 5, 8'h20);
        step();
        step();
        step();
        expect_st("own5_beat3", 1, 5, 8'h20);
        req = 8'h44;
        step();
        expect_st("drop_turn", 0, 5, 8'h00);
        step();
        expect_st("drop_idle", 0, 5, 8'h00);
        step();
        expect_st("next_is6", 1, 6, 8'h40);

        // async reset mid-burst, no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        expect_st("async_reset", 0, 0, 8'h00);
        rst_n = 1'b1;
        req = 8'h00;
        step();
        expect_st("post_reset_idle", 0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
